// File: rtl/softmax_feeder_if.sv
// Buffer read port plus softmax input stream seen by softmax_feeder.
// Member names follow the feeder's point of view: o_* are driven by the feeder.
interface softmax_feeder_if #(
    parameter int unsigned DATA_W = 640,
    parameter int unsigned ADDR_W = 10
);
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DATA_W-1:0] i_rd_data;
    logic              o_start;
    logic [DATA_W-1:0] o_data;
    logic              i_denom_valid;

    modport master (
        output o_rd_en, o_rd_addr, o_start, o_data,
        input  i_rd_data, i_denom_valid
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_start, o_data,
        output i_rd_data, i_denom_valid
    );
endinterface

// File: rtl/softmax_feeder.sv
// Streams BEATS-beat blocks from the score buffer into softmax, one block per
// denominator handshake, with a fixed idle gap ahead of every start pulse.
module softmax_feeder #(
    parameter int unsigned DATA_W = 640,
    parameter int unsigned BEATS  = 16,
    parameter int unsigned GAP    = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_go,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [7:0]        i_num_blk,
    output logic              o_busy,
    output logic              o_done,
    softmax_feeder_if.master  bus
);
    localparam int unsigned J_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BLK_SH = $clog2(BEATS);
    localparam int unsigned GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_READ0, S_START, S_SEND, S_WAIT_DEN, S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [7:0]        r_num;
    logic [7:0]        r_k;
    logic [J_W-1:0]    r_j;
    logic [GAP_CW-1:0] r_gap;
    logic              r_den_seen;
    logic              r_rd_d;
    logic [ADDR_W-1:0] w_blk_addr;

    assign w_blk_addr = r_base + (ADDR_W'(r_k) << BLK_SH);

    // Buffer has one cycle of read latency; o_data carries only returned beats.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_d     <= 1'b0;
            bus.o_data <= '0;
        end else begin
            r_rd_d     <= bus.o_rd_en;
            bus.o_data <= r_rd_d ? bus.i_rd_data : '0;
        end
    end

    // Control FSM; strobes are decoded on the transition so they are registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_num         <= '0;
            r_k           <= '0;
            r_j           <= '0;
            r_gap         <= '0;
            r_den_seen    <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            bus.o_rd_en   <= 1'b0;
            bus.o_rd_addr <= '0;
            bus.o_start   <= 1'b0;
        end else begin
            o_done      <= 1'b0;
            bus.o_rd_en <= 1'b0;
            bus.o_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        o_busy <= 1'b1;
                        if (i_num_blk != 8'd0) begin
                            r_base  <= i_base_addr;
                            r_num   <= i_num_blk;
                            r_k     <= '0;
                            r_gap   <= GAP_CW'(GAP - 1);
                            r_state <= S_GAP;
                        end else begin
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        bus.o_rd_en   <= 1'b1;
                        bus.o_rd_addr <= w_blk_addr;
                        r_state       <= S_READ0;
                    end else begin
                        r_gap <= r_gap - GAP_CW'(1);
                    end
                end
                S_READ0: begin
                    bus.o_start   <= 1'b1;
                    bus.o_rd_en   <= 1'b1;
                    bus.o_rd_addr <= w_blk_addr + ADDR_W'(1);
                    r_state       <= S_START;
                end
                S_START: begin
                    r_den_seen    <= bus.i_denom_valid;
                    bus.o_rd_en   <= 1'b1;
                    bus.o_rd_addr <= w_blk_addr + ADDR_W'(2);
                    r_j           <= '0;
                    r_state       <= S_SEND;
                end
                S_SEND: begin
                    if (bus.i_denom_valid) r_den_seen <= 1'b1;
                    // Last two beats are already in flight; stop issuing reads.
                    if (r_j <= J_W'(BEATS - 4)) begin
                        bus.o_rd_en   <= 1'b1;
                        bus.o_rd_addr <= w_blk_addr + ADDR_W'(r_j) + ADDR_W'(3);
                    end
                    if (r_j == J_W'(BEATS - 1)) begin
                        r_state <= S_WAIT_DEN;
                    end else begin
                        r_j <= r_j + J_W'(1);
                    end
                end
                S_WAIT_DEN: begin
                    if (r_den_seen || bus.i_denom_valid) begin
                        if (r_k + 8'd1 < r_num) begin
                            r_k     <= r_k + 8'd1;
                            r_gap   <= GAP_CW'(GAP - 1);
                            r_state <= S_GAP;
                        end else begin
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/softmax_feeder.md
# softmax_feeder

Streams 16-beat row blocks from the attention score buffer into `softmax`. For each block it issues the single-cycle `i_start` pulse, then drives 16 consecutive 640-bit beats on `i_data`. It then waits for softmax's `o_denom_valid` before launching the next block. It sits between the score SRAM read port and the `softmax` input, and replaces the bench-driven stimulus in the integrated datapath.

## Interface
Parameters:
- `DATA_W`, 640: beat width, 40 lanes × 16 bit; matches `softmax` `i_data`.
- `BEATS`, 16: beats per block.
- `GAP`, 32: idle cycles before each `o_start`.
- `ADDR_W`, 10: buffer address width.

Ports:
- `i_clk`, in, 1: clock; all logic on the rising edge.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_go`, in, 1: launch pulse; sampled only in IDLE.
- `i_base_addr`, in, `ADDR_W`: address of beat 0 of block 0; captured on an accepted `i_go`.
- `i_num_blk`, in, 8: number of blocks; captured on an accepted `i_go`.
- `o_busy`, out, 1: high from the cycle after an accepted `i_go` until the cycle `o_done` is high.
- `o_done`, out, 1: one-cycle pulse when the job completes.
- `o_rd_en`, out, 1: buffer read strobe.
- `o_rd_addr`, out, `ADDR_W`: read address. The buffer returns data one cycle after `o_rd_en`.
- `i_rd_data`, in, `DATA_W`: read data.
- `o_start`, out, 1: to softmax `i_start`.
- `o_data`, out, `DATA_W`: to softmax `i_data`. Registered; zero when no beat is being sent.
- `i_denom_valid`, in, 1: from softmax `o_denom_valid`.

## Operation
- States: IDLE, GAP, READ0, START, SEND, WAIT_DEN, DONE.
- IDLE
  - `i_go`=1 with `i_num_blk`≠0: capture base and count, clear block index k, load the gap counter → GAP.
  - `i_go`=1 with `i_num_blk`=0: → DONE. No reads, no `o_start`.
- GAP: counts `GAP` cycles, then → READ0.
- READ0: `o_rd_en`=1, `o_rd_addr`=base+16k → START.
- START: `o_start`=1, `o_rd_en`=1, `o_rd_addr`=base+16k+1 → SEND.
- SEND (beat counter j=0..15)
  - `o_data` = beat j.
  - `o_rd_en`=1 with addr base+16k+j+2 while j≤13.
  - After j=15 → WAIT_DEN.
  - Exactly 16 reads per block.
- `o_data` register loads `i_rd_data` at the end of each cycle that follows a read, otherwise loads 0. Data passes bit-exact with no lane reordering.
- Denominator flag
  - A sticky flag is cleared in START and set by any `i_denom_valid`=1 sampled in START, SEND or WAIT_DEN.
  - WAIT_DEN leaves when the flag is set or `i_denom_valid`=1 this cycle.
  - If k+1 < num_blk: k++, reload the gap counter → GAP. Otherwise → DONE.
- DONE: `o_done`=1 for one cycle → IDLE.
- Address arithmetic is modulo 2^`ADDR_W` and wraps silently.
- `i_go` while busy is ignored; the captured parameters do not change mid-job.
- `i_denom_valid` in IDLE or GAP is ignored.
- WAIT_DEN has no timeout; it holds indefinitely.

## Timing
- Reset values: `o_busy`, `o_done`, `o_rd_en`, `o_start` = 0; `o_rd_addr` = 0; `o_data` = 0. State = IDLE, all counters 0.
- Reset asserted mid-job returns to IDLE within the same cycle (asynchronous). No `o_done` is produced and the job is abandoned.
- With `i_go` sampled at cycle 0 (block 0):
  - GAP: cycles 1–32.
  - READ0: cycle 33.
  - `o_start`: cycle 34.
  - `o_data` beats 0–15: cycles 35–50.
  - `o_data` = 0 from cycle 51.
  - Earliest WAIT_DEN exit: cycle 51, if `i_denom_valid` was already seen.
- Per block: GAP + 2 + 16 cycles + the denominator wait (minimum 0 extra).
- `o_done` is asserted the cycle after the final WAIT_DEN exit. `o_busy` is 0 the cycle after `o_done`.
- `o_start` is never high in consecutive cycles, and never high while `o_data` is nonzero.

## Test plan
- Single block: base=0, num=1, buffer word n = n+1 replicated per lane; `i_denom_valid` pulsed at cycle 60.
  - `o_start` at cycle 34; `o_data` = 1..16 on cycles 35–50.
  - `o_done` at 61; `o_busy` low at 62.
- Three blocks, base=0x3F8 (wrap): reads 0x3F8..0x3FF then 0x000.., 48 reads total.
  - Second `o_start` exactly GAP+2 cycles after the first `i_denom_valid` is accepted.
- Early denominator: `i_denom_valid` pulsed during SEND beat 5 → WAIT_DEN exits in its first cycle with no stall.
- num=0 → `o_done` the cycle after `i_go`; zero `o_rd_en` and zero `o_start` observed.
- Busy `i_go`: `i_go` with different base/num during SEND → ignored; original job completes unchanged.
- Reset at SEND beat 7:
  - All outputs are 0 immediately.
  - A new `i_go` after release yields `o_start` 34 cycles later.
  - No stale data appears on `o_data`.
